// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - RV32I instruction word encoder with output FIFO
// Encodes a field bundle into a 32-bit instruction and queues it for fetch/decode.
module rv32_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       type_sel_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      imm_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] issued_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    T_R      = 3'd0,
    T_LOAD   = 3'd1,
    T_STORE  = 3'd2,
    T_BRANCH = 3'd3,
    T_I      = 3'd4,
    T_JALR   = 3'd5,
    T_JAL    = 3'd6,
    T_LUI    = 3'd7
  } type_e;

  type_e            type_sel;
  logic [31:0]      word_d;
  logic [31:0]      mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;

  assign type_sel = type_e'(type_sel_i);

  always_comb begin
    word_d = 32'd0;
    case (type_sel)
      T_R:      word_d = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      T_LOAD:   word_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
      T_STORE:  word_d = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
      T_BRANCH: word_d = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], 7'b1100011};
      T_I: begin
        // Shift-immediate forms carry funct7 in the upper bits and a 5-bit shamt.
        if (funct3_i == 3'b001 || funct3_i == 3'b101)
          word_d = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, 7'b0010011};
        else
          word_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
      end
      T_JALR:   word_d = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
      T_JAL:    word_d = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
      T_LUI:    word_d = {imm_i[31:12], rd_i, 7'b0110111};
      default:  word_d = 32'd0;
    endcase
  end

  assign full          = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty         = (wptr_q == rptr_q);
  assign ready_o       = !full && !rst_i;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? 32'd0 : mem_q[rptr_q[AW-1:0]];
  assign err_o         = err_q;
  assign issued_cnt_o  = cnt_q;

  assign push = valid_i && ready_o;
  assign pop  = instr_valid_o && instr_ready_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (push) begin
      wptr_d = wptr_q + (AW+1)'(1);
      err_d  = imm_i[0] && (type_sel == T_BRANCH || type_sel == T_JAL);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wptr_q[AW-1:0]] <= word_d;
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb/tb_rv32_instr_encoder.sv - randomized self-checking bench for rv32_instr_encoder
module tb_rv32_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       type_sel_i;
  logic [4:0]       rd_i, rs1_i, rs2_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [31:0]      imm_i;
  logic [31:0]      instr_o;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic             err_o;
  logic [CNT_W-1:0] issued_cnt_o;

  rv32_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .type_sel_i(type_sel_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .err_o(err_o), .issued_cnt_o(issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        err_exp = 1'b0;
  int          pops    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [2:0] t, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = (rs1 << 15) | (f3 << 12) | (rd << 7);
    case (t)
      3'd0: return (f7 << 25) | (rs2 << 20) | base | 32'h33;
      3'd1: return ((imm & 32'hFFF) << 20) | base | 32'h03;
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
      3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | 32'h63;
      3'd4: if (f3 == 1 || f3 == 5)
              return (f7 << 25) | ((imm & 32'h1F) << 20) | base | 32'h13;
            else
              return ((imm & 32'hFFF) << 20) | base | 32'h13;
      3'd5: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      3'd6: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | 32'h6F;
      default: return (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
    endcase
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(output logic accepted);
    logic pushm, popm;
    logic [31:0] w;
    @(negedge clk_i);
    chk("ready", {31'd0, ready_o}, {31'd0, exp_q.size() < DEPTH});
    chk("valid", {31'd0, instr_valid_o}, {31'd0, exp_q.size() != 0});
    chk("instr", instr_o, exp_q.size() != 0 ? exp_q[0] : 32'd0);
    chk("err", {31'd0, err_o}, {31'd0, err_exp});
    chk("cnt", {28'd0, issued_cnt_o}, (pops > 15) ? 32'd15 : pops);
    pushm = valid_i && (exp_q.size() < DEPTH);
    popm  = instr_ready_i && (exp_q.size() != 0);
    w = ref_enc(type_sel_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
    @(posedge clk_i);
    if (popm) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (pushm) exp_q.push_back(w);
    err_exp = pushm && imm_i[0] && (type_sel_i == 3'd3 || type_sel_i == 3'd6);
    accepted = pushm;
    #1;
  endtask

  task automatic idle();
    logic a;
    valid_i = 1'b0;
    step(a);
  endtask

  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic a;
    int   n;
    type_sel_i = t; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
    valid_i = 1'b1;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      if (n == 3) instr_ready_i = 1'b1;
      step(a);
      n++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    valid_i = 1'b0;
  endtask

  initial begin
    logic a;
    rst_i = 1'b1; valid_i = 1'b0; instr_ready_i = 1'b0;
    type_sel_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0; imm_i = '0;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_cnt", {28'd0, issued_cnt_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    instr_ready_i = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("rtype_word", instr_o, 32'h002081B3);
    chk("rtype_valid", {31'd0, instr_valid_o}, 32'd1);
    idle();
    chk("rtype_cnt", {28'd0, issued_cnt_o}, 32'd1);

    send(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    chk("lui_word", instr_o, 32'h123452B7);
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    chk("store_word", instr_o, 32'h0020A423);
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk("jal_word", instr_o, 32'h008000EF);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    chk("br_word", instr_o, 32'hFE208EE3);
    chk("br_noerr", {31'd0, err_o}, 32'd0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFD);
    chk("br_odd_word", instr_o, 32'hFE208EE3);
    chk("br_odd_err", {31'd0, err_o}, 32'd1);
    idle();
    chk("br_err_clear", {31'd0, err_o}, 32'd0);

    instr_ready_i = 1'b0;
    send(3'd1, 5'd7, 5'd3, 5'd0, 3'd2, 7'd0, 32'h00000010);
    send(3'd4, 5'd8, 5'd4, 5'd0, 3'd5, 7'h20, 32'h00000003);
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    send(3'd5, 5'd9, 5'd6, 5'd0, 3'd7, 7'd0, 32'h00000FFC);
    repeat (4) idle();
    chk("drain_cnt", exp_q.size(), 32'd0);

    instr_ready_i = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    send(3'd0, 5'd4, 5'd5, 5'd6, 3'd7, 7'd0, 32'd0);
    #3;
    rst_i = 1'b1;
    #1;
    chk("amid_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("amid_ready", {31'd0, ready_o}, 32'd0);
    chk("amid_cnt", {28'd0, issued_cnt_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete(); err_exp = 1'b0; pops = 0;
    idle();

    instr_ready_i = 1'b1;
    for (int i = 0; i < 20; i++)
      send(3'd4, 5'(i), 5'd1, 5'd0, 3'd0, 7'd0, 32'(i));
    repeat (2) idle();
    chk("sat_cnt", {28'd0, issued_cnt_o}, 32'd15);

    for (int i = 0; i < 400; i++) begin
      valid_i       = ($urandom_range(0, 3) != 0);
      instr_ready_i = ($urandom_range(0, 2) != 0);
      type_sel_i    = 3'($urandom);
      rd_i          = 5'($urandom);
      rs1_i         = 5'($urandom);
      rs2_i         = 5'($urandom);
      funct3_i      = 3'($urandom);
      funct7_i      = 7'($urandom);
      imm_i         = $urandom;
      step(a);
    end
    valid_i = 1'b0;
    instr_ready_i = 1'b1;
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
